// File: rtl/eth_pkg.sv
// eth_pkg -- constants, types and helpers shared by the Ethernet transmitters
// (ARP, ICMP) and the byte-wide CRC-32 engine.
//   - EtherType / ARP field constants
//   - preamble / SFD bytes
//   - CRC-32 init, reflected polynomial and good-frame residue
//   - transmit FSM state enum and per-state byte counts
//   - crc32_byte(): one reflected CRC-32 step over a byte, LSB first
package eth_pkg;

  localparam logic [15:0] ETH_TYPE_ARP   = 16'h0806;
  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN_ETH   = 8'h06;
  localparam logic [7:0]  ARP_PLEN_IPV4  = 8'h04;
  localparam logic [15:0] ARP_OP_REQ     = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;

  localparam logic [7:0]  PREAMBLE_BYTE  = 8'h55;
  localparam logic [7:0]  SFD_BYTE       = 8'hD5;

  localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;
  // 04C11DB7 bit-reversed, for the LSB-first (reflected) shift register
  localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
  // Register value after a good frame + FCS, in non-reflected form
  localparam logic [31:0] CRC32_RESIDUE   = 32'hC704_DD7B;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    ETH_HDR,
    ARP_DATA,
    FCS,
    IFG
  } tx_state_t;

  localparam int PREAMBLE_LEN = 8;
  localparam int ETH_HDR_LEN  = 14;
  localparam int ARP_DATA_LEN = 46;
  localparam int FCS_LEN      = 4;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc_in,
                                             input logic [7:0]  data);
    logic [31:0] r;
    r = crc_in;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ data[i]) ? CRC32_POLY_REFL : 32'h0);
    end
    return r;
  endfunction

endpackage

// File: rtl/crc32_d8.sv
// crc32_d8 -- byte-wide Ethernet CRC-32 (reflected, init FFFFFFFF).
// The register holds the raw (non-complemented) reflected CRC; the user
// complements it and sends it LSB byte first as the FCS.
//   clk    in   clock
//   rst_n  in   asynchronous active-low reset (register -> init)
//   clr    in   synchronous reload to init (wins over en)
//   en     in   fold data into the CRC this cycle
//   data   in   8-bit input byte
//   crc    out  current CRC register
module crc32_d8
  import eth_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  data,
  output logic [31:0] crc
);

  logic [31:0] crc_next;

  always_comb begin
    crc_next = crc32_byte(crc, data);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= CRC32_INIT;
    end else if (clr) begin
      crc <= CRC32_INIT;
    end else if (en) begin
      crc <= crc_next;
    end
  end

endmodule

// File: rtl/arp_tx.sv
// arp_tx -- builds an Ethernet II ARP request/reply frame and streams it as
// GMII bytes: preamble+SFD, 14-byte MAC header, 46-byte ARP body (incl. pad)
// and 4-byte FCS, then holds off for an inter-frame gap.
//   clk          in   GMII TX clock
//   rst_n        in   asynchronous active-low reset
//   arp_tx_en    in   start pulse, sampled only in IDLE
//   arp_tx_type  in   0 = request, 1 = reply (sampled with arp_tx_en)
//   des_mac      in   peer MAC (sampled with arp_tx_en)
//   des_ip       in   peer IP  (sampled with arp_tx_en)
//   gmii_tx_en   out  frame byte valid
//   gmii_txd     out  frame byte
//   tx_done      out  one-cycle pulse after the last FCS byte
//   tx_busy      out  high from accepted start until the gap has elapsed
module arp_tx
  import eth_pkg::*;
#(
  parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP   = 32'hC0_A8_01_0A,
  parameter int          IFG_CYCLES = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        arp_tx_en,
  input  logic        arp_tx_type,
  input  logic [47:0] des_mac,
  input  logic [31:0] des_ip,
  output logic        gmii_tx_en,
  output logic [7:0]  gmii_txd,
  output logic        tx_done,
  output logic        tx_busy
);

  // state/cnt always name the byte currently on the GMII outputs; the next
  // position is decoded combinationally so its byte can be registered on the
  // same edge the FSM advances, giving one cycle start-to-first-byte latency.
  tx_state_t   state;
  logic [5:0]  cnt;
  tx_state_t   nxt_state;
  logic [5:0]  nxt_cnt;

  logic        reply;
  logic [47:0] mac_lat;
  logic [31:0] ip_lat;

  logic [31:0]  crc;
  logic         crc_en;
  logic         crc_clr;
  logic         frame_on;
  logic [7:0]   nxt_byte;
  logic [111:0] hdr_vec;
  logic [111:0] hdr_sh;
  logic [223:0] arp_vec;
  logic [223:0] arp_sh;
  logic [31:0]  fcs_sh;

  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + 6'd1;
    unique case (state)
      IDLE: begin
        nxt_cnt = '0;
        if (arp_tx_en) nxt_state = PREAMBLE;
      end
      PREAMBLE: if (cnt == 6'(PREAMBLE_LEN - 1)) begin nxt_state = ETH_HDR;  nxt_cnt = '0; end
      ETH_HDR:  if (cnt == 6'(ETH_HDR_LEN - 1))  begin nxt_state = ARP_DATA; nxt_cnt = '0; end
      ARP_DATA: if (cnt == 6'(ARP_DATA_LEN - 1)) begin nxt_state = FCS;      nxt_cnt = '0; end
      FCS:      if (cnt == 6'(FCS_LEN - 1))      begin nxt_state = IFG;      nxt_cnt = '0; end
      IFG:      if (cnt == 6'(IFG_CYCLES - 1))   begin nxt_state = IDLE;     nxt_cnt = '0; end
      default: begin
        nxt_state = IDLE;
        nxt_cnt   = '0;
      end
    endcase
  end

  // Header and ARP body as flat MSB-first vectors; byte n is the top byte
  // after shifting left by 8*n. Shifting past the 28 real ARP bytes yields
  // zeros, which is exactly the 18-byte pad.
  always_comb begin
    hdr_vec  = {(reply ? mac_lat : 48'hFFFF_FFFF_FFFF), BOARD_MAC, ETH_TYPE_ARP};
    arp_vec  = {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN_ETH, ARP_PLEN_IPV4,
                (reply ? ARP_OP_REPLY : ARP_OP_REQ), BOARD_MAC, BOARD_IP,
                (reply ? mac_lat : 48'h0), ip_lat};
    hdr_sh   = hdr_vec << {nxt_cnt, 3'b000};
    arp_sh   = arp_vec << {nxt_cnt, 3'b000};
    fcs_sh   = ~crc >> {nxt_cnt, 3'b000};
    frame_on = (nxt_state == PREAMBLE) || (nxt_state == ETH_HDR) ||
               (nxt_state == ARP_DATA) || (nxt_state == FCS);
    crc_en   = (nxt_state == ETH_HDR) || (nxt_state == ARP_DATA);
    crc_clr  = (state == IDLE);
    unique case (nxt_state)
      PREAMBLE: nxt_byte = (nxt_cnt == 6'(PREAMBLE_LEN - 1)) ? SFD_BYTE : PREAMBLE_BYTE;
      ETH_HDR:  nxt_byte = hdr_sh[111:104];
      ARP_DATA: nxt_byte = arp_sh[223:216];
      FCS:      nxt_byte = fcs_sh[7:0];
      default:  nxt_byte = 8'h00;
    endcase
  end

  // The CRC absorbs each header/body byte on the edge it is registered to
  // the output, so it is complete by the edge that emits the first FCS byte.
  crc32_d8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_en),
    .data  (nxt_byte),
    .crc   (crc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      reply      <= 1'b0;
      mac_lat    <= '0;
      ip_lat     <= '0;
      gmii_tx_en <= 1'b0;
      gmii_txd   <= 8'h00;
      tx_done    <= 1'b0;
      tx_busy    <= 1'b0;
    end else begin
      state      <= nxt_state;
      cnt        <= nxt_cnt;
      gmii_tx_en <= frame_on;
      gmii_txd   <= frame_on ? nxt_byte : 8'h00;
      tx_done    <= (state == FCS) && (nxt_state == IFG);
      if ((state == IDLE) && arp_tx_en) begin
        reply   <= arp_tx_type;
        mac_lat <= des_mac;
        ip_lat  <= des_ip;
        tx_busy <= 1'b1;
      end else if ((state == IFG) && (nxt_state == IDLE)) begin
        tx_busy <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arp_tx.sv
// tb_arp_tx -- directed bench for arp_tx: reply and request frames, start
// pulses during frame and gap, restart after the gap, and mid-frame reset.
module tb_arp_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        arp_tx_en = 1'b0;
  logic        arp_tx_type = 1'b0;
  logic [47:0] des_mac = '0;
  logic [31:0] des_ip = '0;
  logic        gmii_tx_en;
  logic [7:0]  gmii_txd;
  logic        tx_done;
  logic        tx_busy;

  arp_tx dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .arp_tx_en   (arp_tx_en),
    .arp_tx_type (arp_tx_type),
    .des_mac     (des_mac),
    .des_ip      (des_ip),
    .gmii_tx_en  (gmii_tx_en),
    .gmii_txd    (gmii_txd),
    .tx_done     (tx_done),
    .tx_busy     (tx_busy)
  );

  always #4 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  logic [7:0] frm [72];
  logic [7:0] exp_frm [68];
  int         en_count;
  logic       done_seen;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Inputs set at the current negedge; the DUT samples them on the next posedge.
  task automatic start(input logic typ, input logic [47:0] m, input logic [31:0] ip);
    arp_tx_en   = 1'b1;
    arp_tx_type = typ;
    des_mac     = m;
    des_ip      = ip;
    @(negedge clk);
    arp_tx_en = 1'b0;
  endtask

  // Records 72 cycles starting at the current negedge; optionally pokes a
  // start pulse plus changed inputs at byte index poke.
  task automatic capture(input int poke);
    int n;
    n = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 72; i++) begin
      frm[i] = gmii_txd;
      if (gmii_tx_en === 1'b1) n++;
      if (tx_done === 1'b1) done_seen = 1'b1;
      if (i == poke) begin
        arp_tx_en   = 1'b1;
        arp_tx_type = ~arp_tx_type;
        des_mac     = 48'h0102_0304_0506;
        des_ip      = 32'h0A0B_0C0D;
      end else begin
        arp_tx_en = 1'b0;
      end
      @(negedge clk);
    end
    arp_tx_en = 1'b0;
    en_count = n;
  endtask

  function automatic void build_exp(input logic reply, input logic [47:0] m, input logic [31:0] ip);
    logic [47:0] bm;
    logic [31:0] bip;
    logic [47:0] s48;
    logic [47:0] b48;
    logic [31:0] s32;
    logic [31:0] b32;
    bm  = 48'h0011_2233_4455;
    bip = 32'hC0A8_010A;
    for (int i = 0; i < 7; i++) exp_frm[i] = 8'h55;
    exp_frm[7] = 8'hD5;
    for (int k = 0; k < 6; k++) begin
      s48 = m << (8 * k);
      b48 = bm << (8 * k);
      exp_frm[8 + k]  = reply ? s48[47:40] : 8'hFF;
      exp_frm[14 + k] = b48[47:40];
      exp_frm[30 + k] = b48[47:40];
      exp_frm[40 + k] = reply ? s48[47:40] : 8'h00;
    end
    exp_frm[20] = 8'h08; exp_frm[21] = 8'h06;
    exp_frm[22] = 8'h00; exp_frm[23] = 8'h01;
    exp_frm[24] = 8'h08; exp_frm[25] = 8'h00;
    exp_frm[26] = 8'h06; exp_frm[27] = 8'h04;
    exp_frm[28] = 8'h00; exp_frm[29] = reply ? 8'h02 : 8'h01;
    for (int k = 0; k < 4; k++) begin
      s32 = ip << (8 * k);
      b32 = bip << (8 * k);
      exp_frm[36 + k] = b32[31:24];
      exp_frm[46 + k] = s32[31:24];
    end
    for (int i = 50; i < 68; i++) exp_frm[i] = 8'h00;
  endfunction

  // Reflected CRC-32 over bytes 8..71 (FCS included), no final complement,
  // returned bit-reversed so a good frame gives C704DD7B.
  function automatic logic [31:0] fcs_residue();
    logic [31:0] c;
    logic [31:0] r;
    logic        fb;
    c = 32'hFFFF_FFFF;
    for (int i = 8; i < 72; i++) begin
      for (int b = 0; b < 8; b++) begin
        fb = c[0] ^ frm[i][b];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    for (int b = 0; b < 32; b++) r[b] = c[31 - b];
    return r;
  endfunction

  // Called at the negedge right after the capture (expected tx_done cycle).
  task automatic check_frame(input string nm);
    int mm;
    mm = 0;
    chk({nm, "_en_cycles"}, 64'(en_count), 64'd72);
    chk({nm, "_done_in_frame"}, 64'(done_seen), 64'd0);
    chk({nm, "_en_after"}, 64'(gmii_tx_en), 64'd0);
    chk({nm, "_txd_after"}, 64'(gmii_txd), 64'd0);
    chk({nm, "_done_pulse"}, 64'(tx_done), 64'd1);
    for (int i = 0; i < 68; i++) if (frm[i] !== exp_frm[i]) mm++;
    chk({nm, "_body_bytes_wrong"}, 64'(mm), 64'd0);
    chk({nm, "_fcs_residue"}, 64'(fcs_residue()), 64'hC704_DD7B);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int any_en;
    int stray;
    int pad_or;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_tx_en", 64'(gmii_tx_en), 64'd0);
    chk("reset_txd", 64'(gmii_txd), 64'd0);
    chk("reset_done", 64'(tx_done), 64'd0);
    chk("reset_busy", 64'(tx_busy), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_tx_en", 64'(gmii_tx_en), 64'd0);

    // Reply frame, with a start pulse and input changes at byte 20
    build_exp(1'b1, 48'hA0B1_C2D3_E4F5, 32'hC0A8_0166);
    start(1'b1, 48'hA0B1_C2D3_E4F5, 32'hC0A8_0166);
    chk("reply_latency_en", 64'(gmii_tx_en), 64'd1);
    chk("reply_busy", 64'(tx_busy), 64'd1);
    capture(20);
    chk("reply_byte0", 64'(frm[0]), 64'h55);
    chk("reply_sfd", 64'(frm[7]), 64'hD5);
    chk("reply_dst_mac", 64'({frm[8], frm[9], frm[10], frm[11], frm[12], frm[13]}), 64'hA0B1_C2D3_E4F5);
    chk("reply_ethertype", 64'({frm[20], frm[21]}), 64'h0806);
    chk("reply_opcode", 64'({frm[28], frm[29]}), 64'h0002);
    chk("reply_target_ip", 64'({frm[46], frm[47], frm[48], frm[49]}), 64'hC0A8_0166);
    check_frame("reply");

    // Gap: IFG cycle 1 is the tx_done cycle; pulse at cycle 5 must be ignored
    any_en = 0;
    for (int k = 1; k <= 12; k++) begin
      if (gmii_tx_en !== 1'b0) any_en++;
      if (k == 2) chk("reply_done_width", 64'(tx_done), 64'd0);
      if (k == 12) chk("ifg_busy_last", 64'(tx_busy), 64'd1);
      arp_tx_en = (k == 5);
      @(negedge clk);
    end
    chk("ifg_no_frame", 64'(any_en), 64'd0);
    chk("ifg13_busy", 64'(tx_busy), 64'd0);

    // IFG cycle 13: request accepted
    build_exp(1'b0, 48'h6655_4433_2211, 32'hC0A8_0101);
    start(1'b0, 48'h6655_4433_2211, 32'hC0A8_0101);
    chk("req_latency_en", 64'(gmii_tx_en), 64'd1);
    chk("req_latency_byte", 64'(gmii_txd), 64'h55);
    capture(-1);
    chk("req_dst_mac", 64'({frm[8], frm[9], frm[10], frm[11], frm[12], frm[13]}), 64'hFFFF_FFFF_FFFF);
    chk("req_opcode", 64'({frm[28], frm[29]}), 64'h0001);
    chk("req_target_mac", 64'({frm[40], frm[41], frm[42], frm[43], frm[44], frm[45]}), 64'h0);
    pad_or = 0;
    for (int i = 50; i < 68; i++) pad_or = pad_or | int'(frm[i]);
    chk("req_pad", 64'(pad_or), 64'd0);
    check_frame("request");

    // Reset mid-frame at byte 30
    repeat (14) @(negedge clk);
    start(1'b1, 48'h1234_5678_9ABC, 32'h0A00_0001);
    for (int i = 0; i < 30; i++) @(negedge clk);
    chk("abort_pre_en", 64'(gmii_tx_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_tx_en", 64'(gmii_tx_en), 64'd0);
    chk("abort_txd", 64'(gmii_txd), 64'd0);
    chk("abort_busy", 64'(tx_busy), 64'd0);
    stray = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (80) begin
      @(negedge clk);
      if ((tx_done !== 1'b0) || (gmii_tx_en !== 1'b0)) stray++;
    end
    chk("abort_no_done", 64'(stray), 64'd0);

    // Recovery frame
    build_exp(1'b1, 48'h0A1B_2C3D_4E5F, 32'hC0A8_0002);
    start(1'b1, 48'h0A1B_2C3D_4E5F, 32'hC0A8_0002);
    chk("recover_latency_byte", 64'(gmii_txd), 64'h55);
    capture(-1);
    check_frame("recover");
    @(negedge clk);
    chk("recover_done_width", 64'(tx_done), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
